lsu_subword: RTL
================

Name: lsu_subword

Overview:
- Parametrised next-generation load/store unit between the decode/execute stage and the data cache.
- Accepts one memory request at a time over a valid/ready handshake.
- Supports byte, halfword, word and (when DATA_WIDTH=64) doubleword accesses, with byte-enable generation, write-lane steering, and load extraction with sign/zero extension.
- Detects misaligned accesses, and times out a stalled cache.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; 32 or 64.
- BYTE_DATA_WIDTH, DATA_WIDTH/8, bytes per bus word (byte_enable width).
- TIMEOUT_CYCLES, 255, cache wait cycles before error response; 0 disables timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mem_req  input  1  request valid
- mem_ready  output  1  LSU can accept request
- mem_we  input  1  1=store, 0=load
- mem_size  input  2  log2 bytes: 0=B, 1=H, 2=W, 3=D
- mem_unsigned  input  1  load zero-extends when 1
- mem_addr  input  DATA_WIDTH  byte address
- mem_wdata  input  DATA_WIDTH  store data, right-aligned
- mem_valid  output  1  response valid, one-cycle pulse
- mem_rdata  output  DATA_WIDTH  extended load result; 0 for stores
- mem_error  output  2  0=ok, 1=misaligned, 2=illegal size, 3=timeout
- data_req  output  1  cache request, held until data_valid
- data_addr  output  DATA_WIDTH  mem_addr with low log2(BYTE_DATA_WIDTH) bits cleared
- data_valid  input  1  cache completion
- rdata  input  DATA_WIDTH  cache read word
- wdata  output  DATA_WIDTH  store data shifted to byte lane
- inst_we  output  1  cache write enable
- byte_enable  output  BYTE_DATA_WIDTH  active lanes

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (rst=1 at posedge): state=IDLE. mem_ready=1; every other output 0; timeout counter 0. Reset mid-ACCESS abandons the request: data_req drops next cycle and no response is issued.
- IDLE:
  - mem_ready=1. Request accepted on the edge where mem_req=1; all request fields are registered.
  - Illegal size (mem_size=3 with DATA_WIDTH=32) -> RESP with error 2.
  - Misaligned (mem_addr & ((1<<mem_size)-1) != 0) -> RESP with error 1.
  - Illegal size takes priority over misaligned.
  - Otherwise -> ACCESS.
- ACCESS:
  - Outputs: data_req=1; data_addr, inst_we, wdata and byte_enable driven from registers and stable until data_valid.
  - Byte offset off = addr low bits.
  - byte_enable = ((1<<(1<<size))-1) << off.
  - wdata = mem_wdata << (8*off); bytes outside the enabled lanes are don't-care but driven as shifted data.
  - data_valid=1 -> capture rdata, go to RESP.
  - Timeout counter increments each ACCESS cycle without data_valid. When it reaches TIMEOUT_CYCLES -> RESP with error 3; data_req drops.
  - data_valid in the same cycle the counter reaches the limit: data wins, error 0.
  - A data_valid arriving in IDLE or RESP is ignored.
- RESP:
  - Outputs: mem_valid=1 for exactly one cycle; mem_ready=0. Then -> IDLE.
  - A new request is accepted no earlier than the cycle after RESP.
  - Load extraction: field = rdata >> (8*off), truncated to 8<<size bits. Sign-extended from its MSB unless mem_unsigned=1 or size equals full width.
  - mem_rdata=0 for stores and for error responses.
- Latency: a cache hit with data_valid in the first ACCESS cycle gives mem_valid 2 cycles after acceptance. Errors give mem_valid 1 cycle after acceptance.
- Outputs are registered; no combinational path from mem_* to data_*.
- Counter width: clog2(TIMEOUT_CYCLES+1). It is cleared on entry to ACCESS.

Test Plan:
- Reset: hold rst 2 cycles during ACCESS with data_req=1 -> data_req=0 and mem_ready=1 after reset; no mem_valid.
- Signed byte load:
  - Stimulus: addr=0x1003, size=0, unsigned=0, rdata=0x80_00_00_00, data_valid on first ACCESS cycle.
  - Response: data_addr=0x1000, byte_enable=4'b1000, mem_rdata=0xFFFFFF80, error 0, mem_valid 2 cycles after accept.
- Halfword store:
  - Stimulus: addr=0x2002, size=1, wdata=0x0000BEEF.
  - Response: inst_we=1, byte_enable=4'b1100, wdata[31:16]=0xBEEF, mem_rdata=0.
- Misaligned and illegal size:
  - word at addr=0x2001 -> no data_req; mem_valid next cycle with error 1.
  - size=3 with DATA_WIDTH=32 -> error 2.
- Timeout:
  - TIMEOUT_CYCLES=4, data_valid never asserted -> data_req high for 4 cycles, then mem_valid with error 3.
  - Repeat with data_valid on cycle 4 -> error 0.
- 64-bit instance:
  - Doubleword load at 0x08 -> byte_enable=8'hFF, mem_rdata=rdata.
  - Unsigned word load at 0x0C with rdata[63:32]=0x80000001 -> mem_rdata=0x0000000080000001.

Source files
------------

// File: rtl/lsu_subword.sv
// Sub-word load/store unit sitting between execute and the data cache.
// Takes one request at a time, checks size and alignment, steers store data
// onto its byte lanes, extracts and extends load data, and gives up on a
// cache that does not answer within TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | ready for a request; mem_ready high
// ACCESS | cache request outstanding; data_req high, timeout counter running
// RESP   | one-cycle response pulse on mem_valid
module lsu_subword #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_req,
    output logic                       mem_ready,
    input  logic                       mem_we,
    input  logic [1:0]                 mem_size,
    input  logic                       mem_unsigned,
    input  logic [DATA_WIDTH-1:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       mem_valid,
    output logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [1:0]                 mem_error,
    output logic                       data_req,
    output logic [DATA_WIDTH-1:0]      data_addr,
    input  logic                       data_valid,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       inst_we,
    output logic [BYTE_DATA_WIDTH-1:0] byte_enable
);

    localparam int OFF_W = $clog2(BYTE_DATA_WIDTH);
    // A zero timeout still needs a legal one-bit counter; it simply never fires.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_SIZE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [1:0]                 size_q, size_d;
    logic                       uns_q, uns_d;
    logic [OFF_W-1:0]           off_q, off_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       mem_ready_q, mem_ready_d;
    logic                       mem_valid_q, mem_valid_d;
    logic [DATA_WIDTH-1:0]      mem_rdata_q, mem_rdata_d;
    logic [1:0]                 mem_error_q, mem_error_d;
    logic                       data_req_q, data_req_d;
    logic [DATA_WIDTH-1:0]      data_addr_q, data_addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       inst_we_q, inst_we_d;
    logic [BYTE_DATA_WIDTH-1:0] be_q, be_d;

    logic [OFF_W-1:0]           req_off;
    logic                       req_illegal;
    logic                       req_misaligned;
    logic [BYTE_DATA_WIDTH-1:0] req_be_base;
    logic [BYTE_DATA_WIDTH-1:0] req_be;
    logic [DATA_WIDTH-1:0]      req_wdata;
    logic [DATA_WIDTH-1:0]      req_daddr;

    logic [DATA_WIDTH-1:0]      ld_shifted;
    logic [DATA_WIDTH-1:0]      ld_mask;
    logic [DATA_WIDTH-1:0]      ld_msb;
    logic                       ld_sign;
    logic [DATA_WIDTH-1:0]      ld_data;

    logic [CNT_W-1:0]           cnt_inc;
    logic                       timeout_hit;

    // Decode an incoming request: legality, alignment, lane mask and steered data.
    always_comb begin
        req_off        = mem_addr[OFF_W-1:0];
        req_illegal    = (BYTE_DATA_WIDTH < 8) && (mem_size == 2'd3);
        req_misaligned = 1'b0;
        for (int i = 0; i < OFF_W; i++) begin
            if (i < int'(mem_size)) req_misaligned = req_misaligned | mem_addr[i];
        end
        req_be_base = '0;
        for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
            req_be_base[i] = (i < (1 << mem_size));
        end
        req_be    = req_be_base << req_off;
        req_wdata = mem_wdata << {req_off, 3'b000};
        req_daddr = mem_addr;
        req_daddr[OFF_W-1:0] = '0;
    end

    // Load extraction: shift the addressed field down, then zero or sign extend.
    // A full-width mask leaves nothing above the MSB, so full-width loads pass through.
    always_comb begin
        ld_shifted = rdata >> {off_q, 3'b000};
        ld_mask    = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << size_q));
        ld_msb     = ld_mask & ~(ld_mask >> 1);
        ld_sign    = (|(ld_shifted & ld_msb)) & ~uns_q;
        ld_data    = (ld_shifted & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_ready_d = mem_ready_q;
        mem_valid_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_error_d = mem_error_q;
        data_req_d  = data_req_q;
        data_addr_d = data_addr_q;
        wdata_d     = wdata_q;
        inst_we_d   = inst_we_q;
        be_d        = be_q;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    size_d      = mem_size;
                    uns_d       = mem_unsigned;
                    off_d       = req_off;
                    mem_ready_d = 1'b0;
                    mem_rdata_d = '0;
                    if (req_illegal) begin
                        state_d     = S_RESP;
                        mem_valid_d = 1'b1;
                        mem_error_d = ERR_SIZE;
                    end else if (req_misaligned) begin
                        state_d     = S_RESP;
                        mem_valid_d = 1'b1;
                        mem_error_d = ERR_ALIGN;
                    end else begin
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        data_req_d  = 1'b1;
                        data_addr_d = req_daddr;
                        wdata_d     = req_wdata;
                        inst_we_d   = mem_we;
                        be_d        = req_be;
                    end
                end
            end
            S_ACCESS: begin
                // Data that lands on the timeout cycle still counts as a hit.
                if (data_valid || timeout_hit) begin
                    state_d     = S_RESP;
                    mem_valid_d = 1'b1;
                    mem_error_d = data_valid ? ERR_OK : ERR_TIMEOUT;
                    mem_rdata_d = (data_valid && !inst_we_q) ? ld_data : '0;
                    data_req_d  = 1'b0;
                    data_addr_d = '0;
                    wdata_d     = '0;
                    inst_we_d   = 1'b0;
                    be_d        = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                mem_ready_d = 1'b1;
                mem_rdata_d = '0;
                mem_error_d = ERR_OK;
            end
            default: begin
                state_d     = S_IDLE;
                mem_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            cnt_q       <= '0;
            mem_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_rdata_q <= '0;
            mem_error_q <= ERR_OK;
            data_req_q  <= 1'b0;
            data_addr_q <= '0;
            wdata_q     <= '0;
            inst_we_q   <= 1'b0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mem_ready_q <= mem_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_error_q <= mem_error_d;
            data_req_q  <= data_req_d;
            data_addr_q <= data_addr_d;
            wdata_q     <= wdata_d;
            inst_we_q   <= inst_we_d;
            be_q        <= be_d;
        end
    end

    assign mem_ready   = mem_ready_q;
    assign mem_valid   = mem_valid_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_error   = mem_error_q;
    assign data_req    = data_req_q;
    assign data_addr   = data_addr_q;
    assign wdata       = wdata_q;
    assign inst_we     = inst_we_q;
    assign byte_enable = be_q;

endmodule
